// File: rtl/seg7_pattern_decoder.sv
// Seven-segment receive monitor: deglitches the segment bus, decodes stable
// patterns to BCD and flags digits that break the mod-10 up-count order.
module seg7_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg,
  output logic [3:0]       digit,
  output logic             valid,
  output logic             invalid,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] digit_count,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Returns {is_digit, bcd_code} for a 7-bit a..g pattern.
  function automatic logic [4:0] decode_pattern(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1111110: res = 5'b1_0000;
      7'b0110000: res = 5'b1_0001;
      7'b1101101: res = 5'b1_0010;
      7'b1111001: res = 5'b1_0011;
      7'b0110011: res = 5'b1_0100;
      7'b1011011: res = 5'b1_0101;
      7'b1011111: res = 5'b1_0110;
      7'b1110000: res = 5'b1_0111;
      7'b1111111: res = 5'b1_1000;
      7'b1110011: res = 5'b1_1001;
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    logic [3:0] res;
    if (d >= 4'd9) begin
      res = 4'd0;
    end else begin
      res = d + 4'd1;
    end
    return res;
  endfunction

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] res;
    if (v == ERR_MAX) begin
      res = v;
    end else begin
      res = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic [7:0]       seg_q;
  logic [6:0]       cand_q, cand_d;
  logic             cand_vld_q, cand_vld_d;
  logic [3:0]       stab_q, stab_d;
  logic [6:0]       last_q;
  logic             last_vld_q;
  state_t           state_q;
  logic [3:0]       digit_q;
  logic             valid_q, invalid_q, seq_err_q, locked_q;
  logic [CNT_W-1:0] digit_count_q;
  logic [ERR_W-1:0] err_count_q;

  logic [6:0]       pat_s;
  logic             new_run_s;
  logic             accept_s;
  logic [4:0]       dec_s;
  logic             dec_ok_s;
  logic [3:0]       dec_code_s;
  logic             unused_dp_s;

  // The decimal point carries no digit information and is deliberately dropped.
  assign unused_dp_s = seg_q[0];
  assign pat_s       = seg_q[7:1];
  assign dec_s       = decode_pattern(pat_s);
  assign dec_ok_s    = dec_s[4];
  assign dec_code_s  = dec_s[3:0];

  // Stability run tracking and accept-event detection.
  always_comb begin
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    stab_d     = stab_q;
    new_run_s  = (!cand_vld_q) || (pat_s != cand_q);
    if (new_run_s) begin
      cand_d     = pat_s;
      cand_vld_d = 1'b1;
      stab_d     = 4'd1;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 4'd1;
    end else begin
      stab_d = stab_q;
    end
    // Only the edge that reaches the threshold counts, so a saturated run fires once.
    accept_s = (stab_d == STAB_MAX) && (new_run_s || (stab_q != STAB_MAX)) &&
               ((!last_vld_q) || (pat_s != last_q));
  end

  // Input sampling and stability/last-accepted registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= 8'h00;
      cand_q     <= 7'h00;
      cand_vld_q <= 1'b0;
      stab_q     <= 4'd0;
      last_q     <= 7'h00;
      last_vld_q <= 1'b0;
    end else begin
      seg_q      <= seg;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      stab_q     <= stab_d;
      if (accept_s) begin
        last_q     <= pat_s;
        last_vld_q <= 1'b1;
      end else begin
        last_q     <= last_q;
        last_vld_q <= last_vld_q;
      end
    end
  end

  // SYNC/TRACK state machine with registered pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SYNC;
      digit_q       <= 4'd0;
      valid_q       <= 1'b0;
      invalid_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      digit_count_q <= {CNT_W{1'b0}};
      err_count_q   <= {ERR_W{1'b0}};
    end else begin
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      seq_err_q <= 1'b0;
      if (accept_s && dec_ok_s) begin
        digit_q       <= dec_code_s;
        valid_q       <= 1'b1;
        digit_count_q <= digit_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_q       <= TRACK;
        locked_q      <= 1'b1;
        case (state_q)
          TRACK: begin
            // digit_q still holds the previous accepted digit here.
            if (dec_code_s != next_digit(digit_q)) begin
              seq_err_q   <= 1'b1;
              err_count_q <= err_sat_inc(err_count_q);
            end else begin
              err_count_q <= err_count_q;
            end
          end
          SYNC:    err_count_q <= err_count_q;
          default: err_count_q <= err_count_q;
        endcase
      end else if (accept_s) begin
        invalid_q   <= 1'b1;
        err_count_q <= err_sat_inc(err_count_q);
        state_q     <= SYNC;
        locked_q    <= 1'b0;
      end else begin
        state_q  <= state_q;
        locked_q <= locked_q;
      end
    end
  end

  assign digit       = digit_q;
  assign valid       = valid_q;
  assign invalid     = invalid_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;
  assign digit_count = digit_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed table-driven bench for seg7_pattern_decoder, plus a narrow
// error-counter instance and a reset-before-pulse sequence.
module tb_seg7_pattern_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  digit;
  logic        valid, invalid, seq_err, locked;
  logic [15:0] digit_count;
  logic [7:0]  err_count;

  logic        rst2;
  logic [7:0]  seg2;
  logic [3:0]  digit2;
  logic        valid2, invalid2, seq_err2, locked2;
  logic [15:0] digit_count2;
  logic [1:0]  err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_pattern_decoder #(.STABLE_CYCLES(2), .ERR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .seg(seg), .digit(digit), .valid(valid),
    .invalid(invalid), .seq_err(seq_err), .locked(locked),
    .digit_count(digit_count), .err_count(err_count)
  );

  seg7_pattern_decoder #(.STABLE_CYCLES(2), .ERR_W(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst2), .seg(seg2), .digit(digit2), .valid(valid2),
    .invalid(invalid2), .seq_err(seq_err2), .locked(locked2),
    .digit_count(digit_count2), .err_count(err_count2)
  );

  typedef struct {
    logic [7:0]  seg;
    int          hold;
    logic [2:0]  ev;    // {valid, invalid, seq_err} expected at the third edge
    logic [3:0]  dig;
    logic [15:0] dc;
    logic [7:0]  ec;
    logic        lk;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{8'hFC, 4, 3'b100, 4'd0, 16'd1,  8'd0, 1'b1};
    vecs[1]  = '{8'h60, 4, 3'b100, 4'd1, 16'd2,  8'd0, 1'b1};
    vecs[2]  = '{8'hDA, 4, 3'b100, 4'd2, 16'd3,  8'd0, 1'b1};
    vecs[3]  = '{8'hF2, 4, 3'b100, 4'd3, 16'd4,  8'd0, 1'b1};
    vecs[4]  = '{8'h66, 4, 3'b100, 4'd4, 16'd5,  8'd0, 1'b1};
    vecs[5]  = '{8'hB6, 4, 3'b100, 4'd5, 16'd6,  8'd0, 1'b1};
    vecs[6]  = '{8'hBE, 4, 3'b100, 4'd6, 16'd7,  8'd0, 1'b1};
    vecs[7]  = '{8'hE0, 4, 3'b100, 4'd7, 16'd8,  8'd0, 1'b1};
    vecs[8]  = '{8'hFE, 4, 3'b100, 4'd8, 16'd9,  8'd0, 1'b1};
    vecs[9]  = '{8'hE6, 4, 3'b100, 4'd9, 16'd10, 8'd0, 1'b1};
    vecs[10] = '{8'hFC, 4, 3'b100, 4'd0, 16'd11, 8'd0, 1'b1};
    vecs[11] = '{8'h60, 4, 3'b100, 4'd1, 16'd12, 8'd0, 1'b1};
    vecs[12] = '{8'hDA, 4, 3'b100, 4'd2, 16'd13, 8'd0, 1'b1};
    vecs[13] = '{8'hF2, 5, 3'b100, 4'd3, 16'd14, 8'd0, 1'b1};
    vecs[14] = '{8'hFE, 1, 3'b000, 4'd3, 16'd14, 8'd0, 1'b1};
    vecs[15] = '{8'hF2, 4, 3'b000, 4'd3, 16'd14, 8'd0, 1'b1};
    vecs[16] = '{8'h66, 4, 3'b100, 4'd4, 16'd15, 8'd0, 1'b1};
    vecs[17] = '{8'hBE, 4, 3'b101, 4'd6, 16'd16, 8'd1, 1'b1};
    vecs[18] = '{8'h80, 4, 3'b010, 4'd6, 16'd16, 8'd2, 1'b0};
    vecs[19] = '{8'hE0, 4, 3'b100, 4'd7, 16'd17, 8'd2, 1'b1};
    vecs[20] = '{8'h00, 4, 3'b010, 4'd7, 16'd17, 8'd3, 1'b0};
    vecs[21] = '{8'h61, 4, 3'b100, 4'd1, 16'd18, 8'd3, 1'b1};
    vecs[22] = '{8'h60, 4, 3'b000, 4'd1, 16'd18, 8'd3, 1'b1};

    rst  = 1'b1;
    rst2 = 1'b1;
    seg  = 8'hFC;
    seg2 = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit",   {28'd0, digit}, 32'd0);
    check("rst_pulses",  {29'd0, valid, invalid, seq_err}, 32'd0);
    check("rst_locked",  {31'd0, locked}, 32'd0);
    check("rst_dcount",  {16'd0, digit_count}, 32'd0);
    check("rst_ecount",  {24'd0, err_count}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 23; v++) begin
      seg = vecs[v].seg;
      for (int i = 0; i < vecs[v].hold; i++) begin
        @(posedge clk);
        #1;
        check($sformatf("pulse_v%0d_c%0d", v, i), {29'd0, valid, invalid, seq_err},
              {29'd0, (i == 2) ? vecs[v].ev : 3'b000});
      end
      check($sformatf("digit_v%0d", v),  {28'd0, digit}, {28'd0, vecs[v].dig});
      check($sformatf("dcount_v%0d", v), {16'd0, digit_count}, {16'd0, vecs[v].dc});
      check($sformatf("ecount_v%0d", v), {24'd0, err_count}, {24'd0, vecs[v].ec});
      check($sformatf("locked_v%0d", v), {31'd0, locked}, {31'd0, vecs[v].lk});
      @(negedge clk);
    end

    // Reset lands on the edge where the pulse for digit 2 would appear.
    seg = 8'hDA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_pulse", {29'd0, valid, invalid, seq_err}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_pulses", {29'd0, valid, invalid, seq_err}, 32'd0);
    check("rst_mid_digit",  {28'd0, digit}, 32'd0);
    check("rst_mid_locked", {31'd0, locked}, 32'd0);
    check("rst_mid_dcount", {16'd0, digit_count}, 32'd0);
    check("rst_mid_ecount", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_pulses", {29'd0, valid, invalid, seq_err}, 32'd0);
    check("post_rst_dcount", {16'd0, digit_count}, 32'd0);

    // Narrow error counter: alternating invalid patterns saturate at 3.
    @(negedge clk);
    rst2 = 1'b0;
    for (int n = 0; n < 5; n++) begin
      seg2 = (n % 2 == 0) ? 8'h80 : 8'h00;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        check($sformatf("sat_pulse_n%0d_c%0d", n, i), {29'd0, valid2, invalid2, seq_err2},
              (i == 2) ? 32'd2 : 32'd0);
      end
      check($sformatf("sat_ecount_n%0d", n), {30'd0, err_count2}, (n >= 2) ? 32'd3 : 32'(n + 1));
      check($sformatf("sat_locked_n%0d", n), {31'd0, locked2}, 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
